// File: rtl/cp0_exc_ctrl_pkg.sv
// Shared constants for the WB-stage exception/ERET commit sequencer:
// ExcCode values, exception flag bit positions, CP0 addresses and FSM encodings.
package cp0_exc_ctrl_pkg;

    localparam logic [4:0] EXC_INT  = 5'h00;
    localparam logic [4:0] EXC_ADEL = 5'h04;
    localparam logic [4:0] EXC_ADES = 5'h05;
    localparam logic [4:0] EXC_SYS  = 5'h08;
    localparam logic [4:0] EXC_BP   = 5'h09;
    localparam logic [4:0] EXC_RI   = 5'h0A;
    localparam logic [4:0] EXC_OV   = 5'h0C;

    // wb_exc bit positions; ascending index is descending priority
    localparam int BIT_ADEL_F = 0;
    localparam int BIT_RI     = 1;
    localparam int BIT_OV     = 2;
    localparam int BIT_SYS    = 3;
    localparam int BIT_BP     = 4;
    localparam int BIT_ADEL_D = 5;
    localparam int BIT_ADES   = 6;

    localparam logic [5:0] CP0ADDR_STATUS = 6'd12;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FLUSH = 2'd1;
    localparam logic [1:0] ST_REDIR = 2'd2;

    typedef struct packed {
        logic       any;
        logic [4:0] code;
        logic       is_addr_fault;
        logic       is_adel_f;
    } prio_t;

endpackage

// File: rtl/cp0_exc_ctrl_if.sv
// WB-stage <-> exception controller signal bundle.
interface cp0_exc_ctrl_if;

    logic        wb_valid;
    logic [31:0] wb_PC;
    logic        wb_BD;
    logic [6:0]  wb_exc;
    logic [31:0] wb_badvaddr;
    logic        wb_eret;
    logic        int_pending;
    logic        mtc0_we;
    logic [5:0]  cp0_addr;
    logic [31:0] mct0_data;
    logic [31:0] cp0_EPC_data;

    logic        exception;
    logic        EXL;
    logic        BD;
    logic [4:0]  exc_code;
    logic        cause_BD;
    logic        badvaddr_we;
    logic [31:0] badvaddr;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_PC;
    logic        commit_stall;

    modport master (
        output wb_valid, wb_PC, wb_BD, wb_exc, wb_badvaddr, wb_eret,
               int_pending, mtc0_we, cp0_addr, mct0_data, cp0_EPC_data,
        input  exception, EXL, BD, exc_code, cause_BD, badvaddr_we, badvaddr,
               flush, redirect_valid, redirect_PC, commit_stall
    );

    modport slave (
        input  wb_valid, wb_PC, wb_BD, wb_exc, wb_badvaddr, wb_eret,
               int_pending, mtc0_we, cp0_addr, mct0_data, cp0_EPC_data,
        output exception, EXL, BD, exc_code, cause_BD, badvaddr_we, badvaddr,
               flush, redirect_valid, redirect_PC, commit_stall
    );

endinterface

// File: rtl/cp0_exc_ctrl_prio_enc.sv
// Combinational priority encoder: {interrupt, wb_exc} -> {any, ExcCode, address-fault flags}.
module cp0_exc_ctrl_prio_enc
    import cp0_exc_ctrl_pkg::*;
(
    input  logic       interrupt,
    input  logic [6:0] exc,
    output prio_t      prio
);

    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned and infers a latch.
    always_comb begin
        prio = '0;
        prio.any = interrupt | (|exc);
        if (interrupt)              prio.code = EXC_INT;
        else if (exc[BIT_ADEL_F]) begin
            prio.code          = EXC_ADEL;
            prio.is_addr_fault = 1'b1;
            prio.is_adel_f     = 1'b1;
        end
        else if (exc[BIT_RI])       prio.code = EXC_RI;
        else if (exc[BIT_OV])       prio.code = EXC_OV;
        else if (exc[BIT_SYS])      prio.code = EXC_SYS;
        else if (exc[BIT_BP])       prio.code = EXC_BP;
        else if (exc[BIT_ADEL_D]) begin
            prio.code          = EXC_ADEL;
            prio.is_addr_fault = 1'b1;
        end
        else if (exc[BIT_ADES]) begin
            prio.code          = EXC_ADES;
            prio.is_addr_fault = 1'b1;
        end
    end

endmodule

// File: rtl/cp0_exc_ctrl.sv
// WB-stage exception/ERET commit sequencer: owns Status.EXL, Cause.BD/ExcCode and
// drives a flush followed by a single-cycle redirect to the vector or EPC.
module cp0_exc_ctrl
    import cp0_exc_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR   = 32'hBFC0_0380,
    parameter int          FLUSH_CYCLES = 2
) (
    input logic           clk,
    input logic           rst_n,
    cp0_exc_ctrl_if.slave bus
);

    localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_CYCLES - 1);

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             exl_q;
    logic [4:0]       exc_code_q;
    logic             cause_bd_q;
    logic [31:0]      redirect_pc_q;

    prio_t prio;
    logic  in_idle;
    logic  take_exc;
    logic  take_eret;
    logic  take_mtc0;
    logic  unused_mtc0_bits;

    cp0_exc_ctrl_prio_enc u_prio_enc (
        .interrupt (bus.int_pending & ~exl_q),
        .exc       (bus.wb_exc),
        .prio      (prio)
    );

    assign in_idle   = (state == ST_IDLE);
    assign take_exc  = in_idle & bus.wb_valid & prio.any;
    assign take_eret = in_idle & bus.wb_valid & bus.wb_eret & ~take_exc;
    assign take_mtc0 = in_idle & bus.mtc0_we & (bus.cp0_addr == CP0ADDR_STATUS)
                     & ~take_exc & ~take_eret;
    assign unused_mtc0_bits = ^{bus.mct0_data[31:2], bus.mct0_data[0]};

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            exl_q         <= 1'b1;
            exc_code_q    <= EXC_INT;
            cause_bd_q    <= 1'b0;
            redirect_pc_q <= EXC_VECTOR;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (take_exc) begin
                        exc_code_q    <= prio.code;
                        redirect_pc_q <= EXC_VECTOR;
                        // Nested exceptions keep the original delay-slot indication.
                        if (!exl_q) cause_bd_q <= bus.wb_BD;
                        exl_q         <= 1'b1;
                        cnt           <= CNT_LOAD;
                        state         <= ST_FLUSH;
                    end else if (take_eret) begin
                        exl_q         <= 1'b0;
                        redirect_pc_q <= bus.cp0_EPC_data;
                        cnt           <= CNT_LOAD;
                        state         <= ST_FLUSH;
                    end else if (take_mtc0) begin
                        exl_q         <= bus.mct0_data[1];
                    end
                end
                ST_FLUSH: begin
                    if (cnt == '0) state <= ST_REDIR;
                    else           cnt   <= cnt - CNT_W'(1);
                end
                ST_REDIR: state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    assign bus.exception      = take_exc;
    assign bus.BD             = bus.wb_BD & take_exc;
    assign bus.EXL            = exl_q;
    assign bus.exc_code       = exc_code_q;
    assign bus.cause_BD       = cause_bd_q;
    assign bus.badvaddr_we    = take_exc & prio.is_addr_fault;
    assign bus.badvaddr       = prio.is_adel_f ? bus.wb_PC : bus.wb_badvaddr;
    assign bus.flush          = (state == ST_FLUSH);
    assign bus.redirect_valid = (state == ST_REDIR);
    assign bus.redirect_PC    = redirect_pc_q;
    assign bus.commit_stall   = ~in_idle;

endmodule
